// File: rtl/bit_packer.sv
// Variable-length code packer: appends right-aligned codes MSB-first into 32-bit words
// behind a 16-word first-word-fall-through FIFO. Define BIT_PACKER_TOTAL_BITS_EN to build the total_bits counter.
module bit_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [63:0] val,
  input  logic [63:0] size_of_bit,
  input  logic        flush_bit,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        flush_done,
  output logic        overflow_err,
  output logic        size_err,
  output logic [31:0] total_bits
);

  localparam int DEPTH = 16;

  typedef enum logic [1:0] {RUN, PAD, DRAIN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] resid_reg, resid_next;
  logic [4:0]  resid_cnt_reg, resid_cnt_next;
  logic [3:0]  wr_ptr_reg, wr_ptr_next;
  logic [3:0]  rd_ptr_reg, rd_ptr_next;
  logic [4:0]  count_reg, count_next;
  logic        overflow_reg, overflow_next;
  logic        size_err_reg, size_err_next;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        size_big;
  logic [6:0]  size_clamped;
  logic [6:0]  size_eff;
  logic [63:0] code_mask;
  logic [95:0] code_ext;
  logic [6:0]  shift_amt;
  logic [95:0] merged;
  logic [6:0]  total_cnt;
  logic [1:0]  pack_words;
  logic [31:0] pack_resid;

  logic [1:0]  push_cnt;
  logic [31:0] push_w0, push_w1;
  logic        pop;
  logic [4:0]  free_cnt;
  logic [1:0]  wr_cnt;
  logic        drop;
  logic [3:0]  wr_ptr_p1;

  assign accept       = (state_reg == RUN) && enable;
  assign size_big     = size_of_bit > 64'd64;
  assign size_clamped = size_big ? 7'd64 : size_of_bit[6:0];
  assign size_eff     = accept ? size_clamped : 7'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_mask
      localparam logic [6:0] BIT_IDX = 7'(gi);
      assign code_mask[gi] = BIT_IDX < size_eff;
    end
  endgenerate

  // Residual sits at the top of a 96-bit window; the new code lands right below it.
  assign code_ext   = {32'h0, val & code_mask};
  assign shift_amt  = 7'd96 - {2'b00, resid_cnt_reg} - size_eff;
  assign merged     = {resid_reg, 64'h0} | (code_ext << shift_amt);
  assign total_cnt  = {2'b00, resid_cnt_reg} + size_eff;
  assign pack_words = total_cnt[6:5];

  always_comb begin
    pack_resid = merged[95:64];
    case (pack_words)
      2'd1:    pack_resid = merged[63:32];
      2'd2:    pack_resid = merged[31:0];
      default: pack_resid = merged[95:64];
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    resid_next     = resid_reg;
    resid_cnt_next = resid_cnt_reg;
    push_cnt       = 2'd0;
    push_w0        = merged[95:64];
    push_w1        = merged[63:32];
    case (state_reg)
      RUN: begin
        push_cnt       = pack_words;
        resid_next     = pack_resid;
        resid_cnt_next = total_cnt[4:0];
        if (flush_bit) state_next = PAD;
      end
      PAD: begin
        // Residual bits below the count are already zero, so it is a ready padded word.
        push_w0        = resid_reg;
        push_cnt       = (resid_cnt_reg != 5'd0) ? 2'd1 : 2'd0;
        resid_next     = 32'h0;
        resid_cnt_next = 5'd0;
        state_next     = DRAIN;
      end
      DRAIN: begin
        if (count_reg == 5'd0) state_next = DONE;
      end
      DONE: begin
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign pop       = (count_reg != 5'd0) && out_ready;
  assign free_cnt  = 5'd16 - count_reg + {4'b0000, pop};
  assign wr_cnt    = ({3'b000, push_cnt} <= free_cnt) ? push_cnt : free_cnt[1:0];
  assign drop      = wr_cnt != push_cnt;
  assign wr_ptr_p1 = wr_ptr_reg + 4'd1;

  assign count_next  = count_reg + {3'b000, wr_cnt} - {4'b0000, pop};
  assign wr_ptr_next = wr_ptr_reg + {2'b00, wr_cnt};
  assign rd_ptr_next = rd_ptr_reg + {3'b000, pop};

  assign overflow_next = overflow_reg | drop
                       | ((state_reg != RUN) && (enable || flush_bit));
  assign size_err_next = size_err_reg | (accept && size_big);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= RUN;
      resid_reg     <= 32'h0;
      resid_cnt_reg <= 5'd0;
      wr_ptr_reg    <= 4'd0;
      rd_ptr_reg    <= 4'd0;
      count_reg     <= 5'd0;
      overflow_reg  <= 1'b0;
      size_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      resid_reg     <= resid_next;
      resid_cnt_reg <= resid_cnt_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      size_err_reg  <= size_err_next;
    end
  end

  // Storage is not reset; an empty count makes stale words invisible.
  always_ff @(posedge clock) begin
    if (wr_cnt != 2'd0) mem[wr_ptr_reg] <= push_w0;
    if (wr_cnt == 2'd2) mem[wr_ptr_p1]  <= push_w1;
  end

  assign out_valid    = count_reg != 5'd0;
  assign out_data     = out_valid ? mem[rd_ptr_reg] : 32'h0;
  assign flush_done   = state_reg == DONE;
  assign overflow_err = overflow_reg;
  assign size_err     = size_err_reg;

`ifdef BIT_PACKER_TOTAL_BITS_EN
  logic [31:0] total_reg;
  logic [31:0] total_add;

  always_comb begin
    total_add = {25'h0, size_eff};
    if (state_reg == PAD && resid_cnt_reg != 5'd0)
      total_add = 32'd32 - {27'h0, resid_cnt_reg};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) total_reg <= 32'h0;
    else          total_reg <= total_reg + total_add;
  end

  assign total_bits = total_reg;
`else
  assign total_bits = 32'h0;
`endif

endmodule

// File: doc/bit_packer.md
BIT_PACKER -- requirements
Module: bit_packer

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  async reset; 0 reset, 1 not reset.
- enable  in  1  input code valid; driven by upstream VLC output_enable.
- val  in  64  code bits, right-aligned.
- size_of_bit  in  64  code length in bits.
- flush_bit  in  1  end-of-slice flush pulse, one cycle.
- out_ready  in  1  consumer accepts out_data this cycle.
- out_valid  out  1  out_data holds a valid word.
- out_data  out  32  packed word, first bit at MSB.
- flush_done  out  1  one-cycle pulse: flush complete, FIFO empty.
- overflow_err  out  1  sticky: a word was dropped because the FIFO was full.
- size_err  out  1  sticky: size_of_bit > 64 seen.
- total_bits  out  32  bits accepted since reset (see REQ-020).

REQ-002 Clocking and reset SHALL be a single clock domain on clock, with reset_n asynchronous and active-low.

Function
REQ-003 Each cycle with enable=1, the low size_of_bit bits of val SHALL be appended MSB-first to a bit accumulator; higher bits of val are ignored.
- size_of_bit=0 appends nothing.
- size_of_bit>64 SHALL be clamped to 64 and SHALL set size_err.
REQ-004 The accumulator SHALL hold at most 95 bits (31 residual + 64 new). Every complete 32-bit group SHALL be written to the output FIFO in arrival order, up to 2 words per cycle. Residual bits SHALL stay left-aligned.
REQ-005 Output FIFO: 16 words, first-word-fall-through. A word written at edge N SHALL be visible on out_data with out_valid=1 after edge N. Write-to-out_valid latency from an enable cycle SHALL be 1 clock.
REQ-006 A word is consumed on an edge where out_valid=1 and out_ready=1. out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-007 A push and a pop in the same cycle SHALL both take effect. A full FIFO with a simultaneous pop SHALL accept one push.
REQ-008 When free space is smaller than the number of words to push, the words that fit SHALL be written and the rest dropped. overflow_err SHALL be set. The residual bit count SHALL still advance as if no word had been dropped.
REQ-009 The state machine SHALL have states RUN, PAD, DRAIN and DONE; the reset state is RUN.
REQ-010 RUN: on flush_bit=1, go to PAD. If enable=1 in the same cycle, that code SHALL be appended before the flush.
REQ-011 PAD: if residual>0, push one word of the residual bits zero-padded on the LSB side, clear the residual, then go to DRAIN. If residual=0, push nothing and go to DRAIN.
REQ-012 DRAIN: stay until the FIFO is empty, then go to DONE.
REQ-013 DONE: assert flush_done for exactly one cycle, then return to RUN.
REQ-014 enable or flush_bit asserted in PAD, DRAIN or DONE SHALL be dropped and SHALL set overflow_err.
REQ-015 overflow_err and size_err SHALL stay set until reset.

Reset
REQ-016 On reset_n=0, all of the following SHALL clear immediately, regardless of any operation in progress:
- out_valid, flush_done, overflow_err and size_err → 0.
- out_data → 32'h0.
- total_bits → 0.
- accumulator, residual count and FIFO pointers/count → 0.
- state → RUN.
REQ-017 All FIFO contents SHALL be discarded on reset.
REQ-018 The first enable accepted after reset_n rises SHALL be packed from bit 0 of a new word.

Configuration
REQ-019 The macro BIT_PACKER_TOTAL_BITS_EN SHALL control the total_bits counter.
REQ-020 With BIT_PACKER_TOTAL_BITS_EN defined:
- total_bits SHALL add the clamped size on each accepted enable, plus the pad-bit count in PAD.
- It SHALL wrap modulo 2^32.
REQ-021 Without BIT_PACKER_TOTAL_BITS_EN, total_bits SHALL be tied to 32'h0 and no counter logic SHALL be built.

Verification
REQ-022 Eleven inputs of val=0x5, size=3, with out_ready=1, then flush → out_data 0xB6DB6DB6, then 0x80000000; flush_done pulses once; total_bits=64.
REQ-023 One input of val=64'hFFFF_FFFF_FFFF_FFFF, size=64 → two words 0xFFFFFFFF on consecutive pops; residual 0; a following flush pushes no word.
REQ-024 out_ready=0 with nine size-64 inputs → FIFO holds 16 words, overflow_err=1 from the ninth input; draining yields exactly 16 words.
REQ-025 val=0x3, size=70 → size_err=1; 64 bits appended (62 zeros, then 11); total_bits +64.
REQ-026 reset_n pulsed low after 20 accumulated bits → out_valid=0, total_bits=0, errors clear. Next input val=0xA, size=4, followed by a flush → 0xA0000000.
REQ-027 flush_bit with an empty accumulator and empty FIFO → no word; flush_done high exactly one cycle, two edges after the flush.
